sram_fifo_ctrl: RTL and testbench

- Parametrised successor SRAM-backed FIFO controller.
- Drives a dual-port SRAM: port A is write-only, port B is read-only with 1-cycle read latency.
- Element size is selectable at runtime (byte/half-word/word/double-word) and packs elements into SRAM words using byte enables.
- Provides true first-word-fall-through through a 2-entry prefetch buffer with write bypass, plus programmable almost-full/almost-empty flags and sticky overflow/underflow flags. Sits between event producers (AER path) and bus/register-file readers.

---
 rtl/sram_fifo_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller over a dual-port SRAM (A write-only,
// B read-only with 1-cycle latency). Elements of 1/2/4/8 bytes, chosen at
// clr time, are packed into SRAM words with byte enables. A 2-entry prefetch
// buffer gives first-word-fall-through, and a push into an idle FIFO
// bypasses the SRAM.
// Ports:
//   clk, rst (sync, active-high), clr (sync flush, latches size)
//   wr_en/wr_data/full, rd_en/rd_data/rd_valid/empty, numel
//   af_thresh/ae_thresh -> almost_full/almost_empty, sticky overflow/underflow
//   sram_*_a : write port, sram_*_b / sram_rdata_b : read port
module sram_fifo_ctrl #(
  parameter int SRAM_WIDTH = 32,
  parameter int SRAM_DEPTH = 16,
  localparam int BYTES = SRAM_WIDTH / 8,
  localparam int BAW   = $clog2(SRAM_DEPTH * BYTES),
  localparam int CNT_W = BAW + 1,
  localparam int AW    = $clog2(SRAM_DEPTH),
  localparam int LB    = $clog2(BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [1:0]            size,
  input  logic                  wr_en,
  input  logic [63:0]           wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [63:0]           rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [CNT_W-1:0]      numel,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  sram_ce_a,
  output logic                  sram_we_a,
  output logic [BYTES-1:0]      sram_be_a,
  output logic [AW-1:0]         sram_addr_a,
  output logic [SRAM_WIDTH-1:0] sram_wdata_a,
  output logic                  sram_ce_b,
  output logic [AW-1:0]         sram_addr_b,
  input  logic [SRAM_WIDTH-1:0] sram_rdata_b
);

  logic [1:0]        size_q, size_d;
  logic [BAW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  numel_q, numel_d, sram_cnt_q, sram_cnt_d;
  logic              infl_q, infl_d;
  logic [LB-1:0]     infl_off_q, infl_off_d;
  logic [1:0][63:0]  buf_q, buf_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [1:0]        size_cl, occ_ap;
  logic [BAW-1:0]    step;
  logic [CNT_W-1:0]  cap;
  logic [63:0]       elem_mask, rd_elem, enq_data;
  logic [SRAM_WIDTH-1:0] rd_shift;
  logic [LB-1:0]     wr_off, lane_mask;
  logic              live, push_acc, pop, bypass, wr_sram, issue, enq;

  assign size_cl   = (size > 2'(LB)) ? 2'(LB) : size;
  assign step      = BAW'(1) << size_q;
  assign cap       = CNT_W'(SRAM_DEPTH * BYTES) >> size_q;
  // Shifting by the full width leaves 0, so the DW case gives all ones.
  assign elem_mask = ~(64'hFFFF_FFFF_FFFF_FFFF << (7'd8 << size_q));
  assign lane_mask = ~({LB{1'b1}} << size_q);
  assign wr_off    = wr_ptr_q[LB-1:0];

  assign full     = (numel_q == cap);
  assign empty    = (numel_q == '0);
  assign rd_valid = (buf_cnt_q != 2'd0);
  assign rd_data  = rd_valid ? buf_q[0] : 64'd0;
  assign numel    = numel_q;
  assign almost_full  = (numel_q >= af_thresh);
  assign almost_empty = (numel_q <= ae_thresh);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // No SRAM traffic or state movement in a flush/reset cycle.
  assign live     = !rst && !clr;
  assign push_acc = live && wr_en && !full;
  assign pop      = live && rd_en && rd_valid;
  assign occ_ap   = buf_cnt_q - 2'(pop);
  // Bypass only when nothing older sits in SRAM or in flight.
  assign bypass   = push_acc && (sram_cnt_q == '0) && !infl_q && (occ_ap < 2'd2);
  assign wr_sram  = push_acc && !bypass;
  // The returning read (if any) lands this cycle, so it counts as occupied.
  assign issue    = live && (sram_cnt_q != '0) && ((occ_ap + 2'(infl_q)) < 2'd2);
  assign enq      = infl_q || bypass;

  assign rd_shift = sram_rdata_b >> {infl_off_q, 3'b000};
  assign rd_elem  = 64'(rd_shift) & elem_mask;
  assign enq_data = infl_q ? rd_elem : (wr_data & elem_mask);

  assign sram_ce_a   = wr_sram;
  assign sram_we_a   = wr_sram;
  assign sram_addr_a = wr_ptr_q[BAW-1:LB];
  assign sram_ce_b   = issue;
  assign sram_addr_b = rd_ptr_q[BAW-1:LB];

  // Each lane takes the element byte matching its position within the
  // element; the enable is set for lanes inside the element being written.
  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    localparam logic [LB-1:0] LANE = LB'(b);
    logic [LB-1:0] src;
    assign src = LANE & lane_mask;
    assign sram_be_a[b] = wr_sram && ((LANE >> size_q) == (wr_off >> size_q));
    assign sram_wdata_a[b*8 +: 8] = wr_data[{src, 3'b000} +: 8];
  end

  always_comb begin
    size_d     = size_q;
    wr_ptr_d   = wr_ptr_q + (push_acc ? step : '0);
    rd_ptr_d   = rd_ptr_q + ((issue || bypass) ? step : '0);
    numel_d    = numel_q + CNT_W'(push_acc) - CNT_W'(pop);
    sram_cnt_d = sram_cnt_q + CNT_W'(wr_sram) - CNT_W'(issue);
    infl_d     = issue;
    infl_off_d = rd_ptr_q[LB-1:0];
    ovf_d      = ovf_q | (wr_en && full);
    unf_d      = unf_q | (rd_en && !rd_valid);
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_d[1]  = 64'd0;
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (enq) begin
      if (buf_cnt_d == 2'd0) buf_d[0] = enq_data;
      else                   buf_d[1] = enq_data;
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
    if (clr) begin
      size_d     = size_cl;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      numel_d    = '0;
      sram_cnt_d = '0;
      infl_d     = 1'b0;
      infl_off_d = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      buf_d      = '0;
      buf_cnt_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q     <= 2'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      numel_q    <= '0;
      sram_cnt_q <= '0;
      infl_q     <= 1'b0;
      infl_off_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      buf_q      <= '0;
      buf_cnt_q  <= 2'd0;
    end else begin
      size_q     <= size_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      numel_q    <= numel_d;
      sram_cnt_q <= sram_cnt_d;
      infl_q     <= infl_d;
      infl_off_q <= infl_off_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl (32-bit x 16 SRAM) with a byte-enable
// SRAM model behind the controller.
module tb_sram_fifo_ctrl;
  localparam int W = 32, D = 16, CW = 7;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [1:0] size = 2'd0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [63:0] wr_data = '0, rd_data;
  logic full, rd_valid, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] numel, af_thresh = 7'd127, ae_thresh = 7'd0;
  logic sram_ce_a, sram_we_a, sram_ce_b;
  logic [3:0] sram_be_a, sram_addr_a, sram_addr_b;
  logic [W-1:0] sram_wdata_a, sram_rdata_b;
  logic [W-1:0] mem [D];

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ce_b) sram_rdata_b <= mem[sram_addr_b];
    if (sram_ce_a && sram_we_a)
      for (int b = 0; b < 4; b++)
        if (sram_be_a[b]) mem[sram_addr_a][b*8 +: 8] <= sram_wdata_a[b*8 +: 8];
  end

  sram_fifo_ctrl #(.SRAM_WIDTH(W), .SRAM_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clr(clr), .size(size),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .numel(numel), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow),
    .sram_ce_a(sram_ce_a), .sram_we_a(sram_we_a), .sram_be_a(sram_be_a),
    .sram_addr_a(sram_addr_a), .sram_wdata_a(sram_wdata_a),
    .sram_ce_b(sram_ce_b), .sram_addr_b(sram_addr_b), .sram_rdata_b(sram_rdata_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_clr(input logic [1:0] s);
    clr = 1'b1; size = s; cyc(); clr = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    wr_en = 1'b1; wr_data = d; cyc(); wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 8 && !rd_valid; i++) cyc();
    chk({tag, "_vld"}, rd_valid, 1'b1);
    chk(tag, rd_data, exp);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
  endtask

  logic [3:0] be_exp [8] = '{4'h0, 4'h0, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic       ce_exp [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // reset state
    cyc(); cyc(); rst = 1'b0;
    chk("rst_empty", empty, 1'b1);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_numel", numel, 0);
    chk("rst_ae", almost_empty, 1'b1);
    chk("rst_ce_a", sram_ce_a, 1'b0);
    chk("rst_ce_b", sram_ce_b, 1'b0);

    // 1: bypass latency
    do_clr(2'd0);
    wr_en = 1'b1; wr_data = 64'h11; #1;
    chk("t1_ce_a", sram_ce_a, 1'b0);
    cyc(); wr_en = 1'b0;
    chk("t1_valid", rd_valid, 1'b1);
    chk("t1_data", rd_data, 64'h11);
    chk("t1_numel", numel, 1);
    pop_chk("t1_pop", 64'h11);
    chk("t1_empty", empty, 1'b1);

    // 2: word fill to full, overflow, ordered drain
    do_clr(2'd2);
    for (int i = 0; i < 16; i++) push(64'h1000 + i);
    chk("t2_full", full, 1'b1);
    chk("t2_numel", numel, 16);
    wr_en = 1'b1; wr_data = 64'hDEAD; #1;
    chk("t2_drop_ce_a", sram_ce_a, 1'b0);
    cyc(); wr_en = 1'b0;
    chk("t2_ovf", overflow, 1'b1);
    chk("t2_numel_ovf", numel, 16);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("t2_pop%0d", i), 64'h1000 + i);
    chk("t2_empty", empty, 1'b0 == 1'b0 ? empty : 1'b0);
    chk("t2_empty_b", empty, 1'b1);

    // 3: byte lanes
    do_clr(2'd0);
    chk("t3_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 64'(i); #1;
      chk($sformatf("t3_ce%0d", i), sram_ce_a, ce_exp[i]);
      chk($sformatf("t3_be%0d", i), sram_be_a, be_exp[i]);
      if (i == 2) chk("t3_addr2", sram_addr_a, 4'd0);
      if (i == 4) chk("t3_addr4", sram_addr_a, 4'd1);
      cyc();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) pop_chk($sformatf("t3_pop%0d", i), 64'(i));

    // 4: streaming push+pop at numel=5 across the byte-64 wrap
    do_clr(2'd0);
    for (int i = 0; i < 5; i++) push(64'(i));
    cyc(); cyc(); cyc();
    for (int j = 0; j < 100; j++) begin
      chk("t4_vld", rd_valid, 1'b1);
      chk($sformatf("t4_data%0d", j), rd_data, 64'(j));
      wr_en = 1'b1; wr_data = 64'(j + 5); rd_en = 1'b1;
      cyc();
      chk("t4_numel", numel, 5);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 100; i < 105; i++) pop_chk($sformatf("t4_tail%0d", i), 64'(i));

    // 5: thresholds and underflow
    af_thresh = 7'd12; ae_thresh = 7'd2;
    do_clr(2'd2);
    for (int i = 0; i < 11; i++) push(64'h500 + i);
    chk("t5_af11", almost_full, 1'b0);
    push(64'h50B);
    chk("t5_af12", almost_full, 1'b1);
    chk("t5_numel12", numel, 12);
    for (int i = 0; i < 12; i++) begin
      if (i == 9) chk("t5_ae3", almost_empty, 1'b0);
      pop_chk($sformatf("t5_pop%0d", i), 64'h500 + i);
      if (i == 9) chk("t5_ae2", almost_empty, 1'b1);
    end
    chk("t5_unf0", underflow, 1'b0);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    chk("t5_unf1", underflow, 1'b1);
    cyc(); cyc();
    chk("t5_unf_sticky", underflow, 1'b1);
    chk("t5_numel0", numel, 0);
    do_clr(2'd2);
    chk("t5_unf_clr", underflow, 1'b0);
    af_thresh = 7'd127; ae_thresh = 7'd0;

    // 6: reset with a read in flight
    for (int i = 0; i < 7; i++) push(64'h600 + i);
    cyc(); cyc(); cyc();
    chk("t6_data0", rd_data, 64'h600);
    rd_en = 1'b1; #1;
    chk("t6_ce_b", sram_ce_b, 1'b1);
    cyc(); rd_en = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_empty", empty, 1'b1);
    chk("t6_valid", rd_valid, 1'b0);
    chk("t6_numel", numel, 0);
    cyc(); cyc();
    chk("t6_late_drop", rd_valid, 1'b0);
    push(64'h5A);
    chk("t6_valid2", rd_valid, 1'b1);
    chk("t6_data2", rd_data, 64'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
